// File: rtl/ex_pkg.sv
// Shared execute-stage types: ALU opcodes, condition codes, NZCV flags and the PC selector.
package ex_pkg;

   typedef enum logic [1:0] {
      ALU_ADD = 2'b00,
      ALU_SUB = 2'b01,
      ALU_AND = 2'b10,
      ALU_OR  = 2'b11
   } alu_op_e;

   typedef enum logic [1:0] {
      COND_AL = 2'b00,
      COND_EQ = 2'b01,
      COND_NE = 2'b10,
      COND_LT = 2'b11
   } cond_e;

   typedef struct packed {
      logic n;
      logic z;
      logic c;
      logic v;
   } flags_t;

   localparam int PC_REG = 15;

endpackage

// File: rtl/ex_alu.sv
// Combinational 2-bit-opcode ALU producing a result and its NZCV flags.
module ex_alu
   import ex_pkg::*;
#(
   parameter int W = 32
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  alu_op_e      op,
   output logic [W-1:0] res,
   output flags_t       nzcv
);

   logic c;
   logic v;

   always_comb begin
      res = '0;
      c   = 1'b0;
      v   = 1'b0;
      case (op)
         ALU_ADD: begin
            {c, res} = {1'b0, a} + {1'b0, b};
            v = (a[W-1] == b[W-1]) && (res[W-1] != a[W-1]);
         end
         ALU_SUB: begin
            res = a - b;
            // carry means "no borrow"
            c = (a >= b);
            v = (a[W-1] != b[W-1]) && (res[W-1] != a[W-1]);
         end
         ALU_AND: res = a & b;
         ALU_OR:  res = a | b;
         default: res = '0;
      endcase
      nzcv.n = res[W-1];
      nzcv.z = (res == '0);
      nzcv.c = c;
      nzcv.v = v;
   end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, NZCV flags, condition check, branch resolve, EX/MEM register.
// Forwarding muxes exist only when EX_STAGE_FORWARD_EN is defined; otherwise operands pass straight through.
module ex_stage #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 4,
   parameter int PC_REG = ex_pkg::PC_REG
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              flush,
   input  logic              regw_in,
   input  logic              flagw_in,
   input  logic              memw_in,
   input  logic              memr_in,
   input  logic              branch_in,
   input  logic              imm_in,
   input  logic [DATA_W-1:0] a_in,
   input  logic [DATA_W-1:0] b_in,
   input  logic [1:0]        alu_ctrl_in,
   input  logic [1:0]        cond_sel_in,
   input  logic [REG_W-1:0]  rs1_in,
   input  logic [REG_W-1:0]  rs2_in,
   input  logic [REG_W-1:0]  rd_in,
   input  logic              mem_regw,
   input  logic              wb_regw,
   input  logic [REG_W-1:0]  mem_rd,
   input  logic [REG_W-1:0]  wb_rd,
   input  logic [DATA_W-1:0] mem_data,
   input  logic [DATA_W-1:0] wb_data,
   output logic              regw_out,
   output logic              memw_out,
   output logic              memr_out,
   output logic [DATA_W-1:0] alu_out,
   output logic [DATA_W-1:0] wdata_out,
   output logic [REG_W-1:0]  rd_out,
   output logic [3:0]        flags_out,
   output logic              branch_taken,
   output logic [DATA_W-1:0] branch_target,
   output logic              flush_req
);
   import ex_pkg::*;

   logic [DATA_W-1:0] op_a;
   logic [DATA_W-1:0] src_b;
   logic [DATA_W-1:0] op_b;
   logic [DATA_W-1:0] res;
   flags_t            alu_flags;
   flags_t            flags_q;
   logic              cond_ok;

`ifdef EX_STAGE_FORWARD_EN
   localparam logic [REG_W-1:0] PC_SEL = REG_W'(PC_REG);

   // MEM is younger than WB, so it wins; the PC register is never a forwarding target
   always_comb begin
      op_a  = a_in;
      src_b = b_in;
      if (rs1_in != PC_SEL && mem_regw && rs1_in == mem_rd)
         op_a = mem_data;
      else if (rs1_in != PC_SEL && wb_regw && rs1_in == wb_rd)
         op_a = wb_data;
      if (rs2_in != PC_SEL && mem_regw && rs2_in == mem_rd)
         src_b = mem_data;
      else if (rs2_in != PC_SEL && wb_regw && rs2_in == wb_rd)
         src_b = wb_data;
   end
`else
   logic unused_fwd;
   assign unused_fwd = ^{mem_regw, wb_regw, mem_rd, wb_rd, mem_data, wb_data,
                         rs1_in, rs2_in, REG_W'(PC_REG)};
   assign op_a  = a_in;
   assign src_b = b_in;
`endif

   assign op_b = imm_in ? b_in : src_b;

   ex_alu #(.W(DATA_W)) u_alu (
      .a    (op_a),
      .b    (op_b),
      .op   (alu_op_e'(alu_ctrl_in)),
      .res  (res),
      .nzcv (alu_flags)
   );

   always_comb begin
      cond_ok = 1'b1;
      case (cond_e'(cond_sel_in))
         COND_AL: cond_ok = 1'b1;
         COND_EQ: cond_ok = flags_q.z;
         COND_NE: cond_ok = !flags_q.z;
         COND_LT: cond_ok = (flags_q.n != flags_q.v);
         default: cond_ok = 1'b1;
      endcase
   end

   assign branch_taken  = branch_in && cond_ok;
   assign branch_target = res;
   assign flush_req     = branch_taken;
   assign flags_out     = flags_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         regw_out  <= 1'b0;
         memw_out  <= 1'b0;
         memr_out  <= 1'b0;
         alu_out   <= '0;
         wdata_out <= '0;
         rd_out    <= '0;
         flags_q   <= '0;
      end else if (flush) begin
         regw_out  <= 1'b0;
         memw_out  <= 1'b0;
         memr_out  <= 1'b0;
         alu_out   <= '0;
         wdata_out <= '0;
         rd_out    <= '0;
      end else if (!stall) begin
         // branches only redirect; they never write a register or memory
         regw_out  <= regw_in && cond_ok && !branch_in;
         memw_out  <= memw_in && cond_ok && !branch_in;
         memr_out  <= memr_in && cond_ok;
         alu_out   <= res;
         wdata_out <= src_b;
         rd_out    <= rd_in;
         if (flagw_in && cond_ok)
            flags_q <= alu_flags;
      end
   end

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: vector table plus hand-written flag, forwarding, stall/flush and reset sequences.
module tb_ex_stage;

   localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, AND_ = 2'b10, OR_ = 2'b11;
   localparam logic [1:0] AL = 2'b00, EQ = 2'b01, NE = 2'b10, LT = 2'b11;
`ifdef EX_STAGE_FORWARD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   typedef struct {
      logic [1:0]  op;
      logic [1:0]  cond;
      logic [31:0] a;
      logic [31:0] b;
      logic        imm, regw, memw, memr, branch, flagw;
      logic [3:0]  rs1, rs2, rd;
   } in_t;

   typedef struct {
      logic        regw, memw, memr;
      logic [31:0] alu, wdata;
      logic [3:0]  rd, flags;
   } out_t;

   typedef struct {
      in_t  i;
      out_t o;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset, stall, flush;
   logic        regw_in, flagw_in, memw_in, memr_in, branch_in, imm_in;
   logic [31:0] a_in, b_in;
   logic [1:0]  alu_ctrl_in, cond_sel_in;
   logic [3:0]  rs1_in, rs2_in, rd_in;
   logic        mem_regw, wb_regw;
   logic [3:0]  mem_rd, wb_rd;
   logic [31:0] mem_data, wb_data;
   logic        regw_out, memw_out, memr_out;
   logic [31:0] alu_out, wdata_out;
   logic [3:0]  rd_out, flags_out;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        flush_req;

   int   checks   = 0;
   int   failures = 0;
   out_t sb[$];
   vec_t v[8];

   always #5 clk = ~clk;

   ex_stage dut (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush),
      .regw_in(regw_in), .flagw_in(flagw_in), .memw_in(memw_in), .memr_in(memr_in),
      .branch_in(branch_in), .imm_in(imm_in), .a_in(a_in), .b_in(b_in),
      .alu_ctrl_in(alu_ctrl_in), .cond_sel_in(cond_sel_in),
      .rs1_in(rs1_in), .rs2_in(rs2_in), .rd_in(rd_in),
      .mem_regw(mem_regw), .wb_regw(wb_regw), .mem_rd(mem_rd), .wb_rd(wb_rd),
      .mem_data(mem_data), .wb_data(wb_data),
      .regw_out(regw_out), .memw_out(memw_out), .memr_out(memr_out),
      .alu_out(alu_out), .wdata_out(wdata_out), .rd_out(rd_out), .flags_out(flags_out),
      .branch_taken(branch_taken), .branch_target(branch_target), .flush_req(flush_req)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   function automatic in_t mk(input logic [1:0] op, input logic [1:0] cond,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic imm, input logic regw, input logic memw,
                              input logic memr, input logic branch, input logic flagw,
                              input logic [3:0] rs1, input logic [3:0] rs2, input logic [3:0] rd);
      in_t x;
      x.op = op; x.cond = cond; x.a = a; x.b = b; x.imm = imm; x.regw = regw;
      x.memw = memw; x.memr = memr; x.branch = branch; x.flagw = flagw;
      x.rs1 = rs1; x.rs2 = rs2; x.rd = rd;
      return x;
   endfunction

   function automatic out_t mko(input logic regw, input logic memw, input logic memr,
                                input logic [31:0] alu, input logic [31:0] wdata,
                                input logic [3:0] rd, input logic [3:0] flags);
      out_t o;
      o.regw = regw; o.memw = memw; o.memr = memr; o.alu = alu;
      o.wdata = wdata; o.rd = rd; o.flags = flags;
      return o;
   endfunction

   task automatic drive(input in_t x);
      alu_ctrl_in = x.op;   cond_sel_in = x.cond; a_in = x.a;       b_in = x.b;
      imm_in      = x.imm;  regw_in     = x.regw; memw_in = x.memw; memr_in = x.memr;
      branch_in   = x.branch; flagw_in  = x.flagw;
      rs1_in      = x.rs1;  rs2_in      = x.rs2;  rd_in   = x.rd;
   endtask

   // expected EX/MEM contents are queued as the stimulus goes in and compared after the edge
   task automatic step(input out_t e, input string tag);
      out_t g;
      sb.push_back(e);
      @(posedge clk);
      #1;
      g = sb.pop_front();
      chk({tag, ".regw"},  32'(regw_out),  32'(g.regw));
      chk({tag, ".memw"},  32'(memw_out),  32'(g.memw));
      chk({tag, ".memr"},  32'(memr_out),  32'(g.memr));
      chk({tag, ".alu"},   alu_out,        g.alu);
      chk({tag, ".wdata"}, wdata_out,      g.wdata);
      chk({tag, ".rd"},    32'(rd_out),    32'(g.rd));
      chk({tag, ".flags"}, 32'(flags_out), 32'(g.flags));
   endtask

   task automatic chk_br(input string tag, input logic taken, input logic [31:0] target);
      chk({tag, ".taken"},  32'(branch_taken), 32'(taken));
      chk({tag, ".freq"},   32'(flush_req),    32'(taken));
      chk({tag, ".target"}, branch_target,     target);
   endtask

   initial begin
      //            op    cond a             b            imm rw mw mr br fw rs1 rs2 rd
      v[0].i = mk(ADD,  AL, 32'd3,        32'd4,        0, 1, 0, 0, 0, 1, 0, 0, 1);
      v[0].o = mko(1, 0, 0, 32'd7,        32'd4,        1, 4'b0000);
      v[1].i = mk(SUB,  AL, 32'd10,       32'd3,        1, 0, 0, 1, 0, 1, 0, 0, 2);
      v[1].o = mko(0, 0, 1, 32'd7,        32'd3,        2, 4'b0010);
      v[2].i = mk(AND_, AL, 32'hF0F0,     32'hFF00,     0, 1, 0, 0, 0, 1, 0, 0, 3);
      v[2].o = mko(1, 0, 0, 32'hF000,     32'hFF00,     3, 4'b0000);
      v[3].i = mk(OR_,  AL, 32'hF0F0,     32'h0F0F,     0, 1, 0, 0, 0, 1, 0, 0, 4);
      v[3].o = mko(1, 0, 0, 32'hFFFF,     32'h0F0F,     4, 4'b0000);
      v[4].i = mk(SUB,  AL, 32'd0,        32'd1,        0, 1, 0, 0, 0, 1, 0, 0, 5);
      v[4].o = mko(1, 0, 0, 32'hFFFFFFFF, 32'd1,        5, 4'b1000);
      v[5].i = mk(ADD,  AL, 32'hFFFFFFFF, 32'd1,        0, 1, 0, 0, 0, 1, 0, 0, 6);
      v[5].o = mko(1, 0, 0, 32'd0,        32'd1,        6, 4'b0110);
      v[6].i = mk(ADD,  AL, 32'd2,        32'd2,        0, 1, 0, 0, 0, 0, 0, 0, 7);
      v[6].o = mko(1, 0, 0, 32'd4,        32'd2,        7, 4'b0110);
      v[7].i = mk(ADD,  AL, 32'h40,       32'h1234,     0, 0, 1, 0, 0, 1, 0, 0, 8);
      v[7].o = mko(0, 1, 0, 32'h1274,     32'h1234,     8, 4'b0000);

      reset = 1'b1; stall = 1'b0; flush = 1'b0;
      mem_regw = 1'b0; wb_regw = 1'b0; mem_rd = 4'd0; wb_rd = 4'd0;
      mem_data = 32'd0; wb_data = 32'd0;
      drive(mk(ADD, AL, 32'd0, 32'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      repeat (2) @(posedge clk);
      #1;
      step(mko(0, 0, 0, 32'd0, 32'd0, 0, 4'b0000), "reset");
      chk_br("reset", 1'b0, 32'd0);

      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (i != 0) @(negedge clk);
         drive(v[i].i);
         step(v[i].o, $sformatf("vec%0d", i));
      end

      // overflow sets N and V, so the following LT branch is not taken
      @(negedge clk);
      drive(mk(ADD, AL, 32'h7FFFFFFF, 32'd1, 1, 1, 0, 0, 0, 1, 0, 0, 2));
      step(mko(1, 0, 0, 32'h80000000, 32'd1, 2, 4'b1001), "ovf");
      @(negedge clk);
      drive(mk(ADD, LT, 32'h10, 32'h4, 1, 0, 0, 0, 1, 0, 0, 0, 9));
      #1 chk_br("ovf_lt", 1'b0, 32'h14);
      step(mko(0, 0, 0, 32'h14, 32'h4, 9, 4'b1001), "ovf_lt");

      // 5-5 gives Z and C; the EQ branch is taken in the same cycle
      @(negedge clk);
      drive(mk(SUB, AL, 32'd5, 32'd5, 0, 1, 0, 0, 0, 1, 0, 0, 1));
      step(mko(1, 0, 0, 32'd0, 32'd5, 1, 4'b0110), "borrow");
      @(negedge clk);
      drive(mk(ADD, EQ, 32'h100, 32'h20, 1, 0, 0, 0, 1, 0, 0, 0, 0));
      #1 chk_br("beq", 1'b1, 32'h120);
      step(mko(0, 0, 0, 32'h120, 32'h20, 0, 4'b0110), "beq");

      // NE with Z=1: nothing is written and the flags keep 0110
      @(negedge clk);
      drive(mk(ADD, NE, 32'd1, 32'd1, 1, 1, 0, 1, 0, 1, 0, 0, 3));
      #1 chk_br("ne_wr", 1'b0, 32'd2);
      step(mko(0, 0, 0, 32'd2, 32'd1, 3, 4'b0110), "ne_wr");
      @(negedge clk);
      drive(mk(ADD, NE, 32'd8, 32'd8, 1, 0, 0, 0, 1, 1, 0, 0, 3));
      #1 chk_br("bne", 1'b0, 32'd16);
      step(mko(0, 0, 0, 32'd16, 32'd8, 3, 4'b0110), "bne");

      @(negedge clk);
      mem_regw = 1'b1; mem_rd = 4'd3; mem_data = 32'hA;
      wb_regw  = 1'b1; wb_rd  = 4'd3; wb_data  = 32'hB;
      drive(mk(ADD, AL, 32'h100, 32'd1, 1, 1, 0, 0, 0, 0, 3, 0, 4));
      step(mko(1, 0, 0, FWD ? 32'hB : 32'h101, 32'd1, 4, 4'b0110), "fwd_mem");
      @(negedge clk);
      mem_regw = 1'b0;
      step(mko(1, 0, 0, FWD ? 32'hC : 32'h101, 32'd1, 4, 4'b0110), "fwd_wb");
      @(negedge clk);
      mem_regw = 1'b1; mem_rd = 4'd15; wb_rd = 4'd15;
      drive(mk(ADD, AL, 32'h100, 32'd1, 1, 1, 0, 0, 0, 0, 15, 0, 4));
      step(mko(1, 0, 0, 32'h101, 32'd1, 4, 4'b0110), "fwd_pc");
      @(negedge clk);
      mem_rd = 4'd3; wb_regw = 1'b0;
      drive(mk(ADD, AL, 32'h100, 32'd7, 0, 1, 0, 0, 0, 0, 0, 3, 4));
      step(mko(1, 0, 0, FWD ? 32'h10A : 32'h107, FWD ? 32'hA : 32'h7, 4, 4'b0110), "fwd_b");
      @(negedge clk);
      drive(mk(ADD, AL, 32'h100, 32'd7, 1, 1, 0, 0, 0, 0, 0, 3, 4));
      step(mko(1, 0, 0, 32'h107, FWD ? 32'hA : 32'h7, 4, 4'b0110), "fwd_imm");
      @(negedge clk);
      mem_regw = 1'b0;

      // stall holds everything; flush wins over stall and leaves the flags alone
      drive(mk(SUB, AL, 32'd5, 32'd3, 0, 1, 0, 0, 0, 1, 0, 0, 4));
      step(mko(1, 0, 0, 32'd2, 32'd3, 4, 4'b0010), "pre_stall");
      @(negedge clk);
      stall = 1'b1;
      drive(mk(SUB, AL, 32'd0, 32'd1, 0, 1, 1, 1, 0, 1, 0, 0, 5));
      for (int k = 0; k < 3; k++)
         step(mko(1, 0, 0, 32'd2, 32'd3, 4, 4'b0010), $sformatf("stall%0d", k));
      @(negedge clk);
      flush = 1'b1;
      step(mko(0, 0, 0, 32'd0, 32'd0, 0, 4'b0010), "stall_flush");
      @(negedge clk);
      flush = 1'b0; stall = 1'b0;

      // reset pulsed between edges is ignored; reset held over an edge clears everything
      drive(mk(ADD, AL, 32'h7FFFFFFF, 32'd1, 1, 1, 0, 0, 0, 1, 0, 0, 6));
      step(mko(1, 0, 0, 32'h80000000, 32'd1, 6, 4'b1001), "pre_rst");
      @(negedge clk);
      stall = 1'b1;
      drive(mk(SUB, AL, 32'd9, 32'd9, 0, 1, 1, 1, 0, 1, 0, 0, 7));
      reset = 1'b1;
      #2 reset = 1'b0;
      step(mko(1, 0, 0, 32'h80000000, 32'd1, 6, 4'b1001), "rst_glitch");
      @(negedge clk);
      reset = 1'b1;
      step(mko(0, 0, 0, 32'd0, 32'd0, 0, 4'b0000), "rst_mid");
      @(negedge clk);
      reset = 1'b0; stall = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
